// File: rtl/counter_loader.sv
// Serial two-byte command front-end for the loadable counter stage:
// synchronises the serial link, decodes LOAD/OE frames, drives the load port.
module counter_loader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_cs,
    input  logic       ser_clk,
    input  logic       ser_data,
    output logic       load_select,
    output logic [7:0] load_value,
    output logic       oe,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        HOLD
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_OE   = 8'h02;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   dat_prev_q, dat_prev_d;

    state_t      state_q, state_d;
    logic [6:0]  shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic        load_select_q, load_select_d;
    logic [7:0]  load_value_q, load_value_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic        cs_rise, cs_fall, sck_rise;
    logic [7:0]  byte_in;

    // Data takes the edge-detect stage too so it stays aligned with the clock event.
    always_comb begin
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], ser_cs};
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], ser_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ser_data};
        cs_prev_d  = cs_sync_q[SYNC_STAGES-1];
        sck_prev_d = sck_sync_q[SYNC_STAGES-1];
        dat_prev_d = dat_sync_q[SYNC_STAGES-1];
    end

    assign cs_rise  = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    assign cs_fall  = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign byte_in  = {shift_q, dat_prev_q};

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        is_load_d     = is_load_q;
        load_select_d = 1'b0;
        load_value_d  = load_value_q;
        oe_d          = oe_q;
        busy_d        = busy_q;
        err_d         = err_q;

        if (cs_fall) begin
            // A frame dropped before its data byte completed is an abort.
            if (state_q == CMD || state_q == DATA) begin
                err_d = 1'b1;
            end
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_rise) begin
                        state_d = CMD;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        cnt_d   = 3'd0;
                        shift_d = 7'd0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        shift_d = byte_in[6:0];
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (byte_in == CMD_LOAD || byte_in == CMD_OE) begin
                                state_d   = DATA;
                                is_load_d = (byte_in == CMD_LOAD);
                            end else begin
                                state_d = HOLD;
                                err_d   = 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        shift_d = byte_in[6:0];
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = HOLD;
                            if (is_load_q) begin
                                load_value_d  = byte_in;
                                load_select_d = 1'b1;
                            end else begin
                                oe_d = byte_in[0];
                            end
                        end
                    end
                end
                HOLD: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q     <= '0;
            sck_sync_q    <= '0;
            dat_sync_q    <= '0;
            cs_prev_q     <= 1'b0;
            sck_prev_q    <= 1'b0;
            dat_prev_q    <= 1'b0;
            state_q       <= IDLE;
            shift_q       <= 7'd0;
            cnt_q         <= 3'd0;
            is_load_q     <= 1'b0;
            load_select_q <= 1'b0;
            load_value_q  <= 8'h00;
            oe_q          <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            cs_sync_q     <= cs_sync_d;
            sck_sync_q    <= sck_sync_d;
            dat_sync_q    <= dat_sync_d;
            cs_prev_q     <= cs_prev_d;
            sck_prev_q    <= sck_prev_d;
            dat_prev_q    <= dat_prev_d;
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            is_load_q     <= is_load_d;
            load_select_q <= load_select_d;
            load_value_q  <= load_value_d;
            oe_q          <= oe_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign load_select = load_select_q;
    assign load_value  = load_value_q;
    assign oe          = oe_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule
